// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation codes, forwarding selects and the EX/MEM payload.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluNor  = 4'd5,
        AluSlt  = 4'd6,
        AluSltu = 4'd7,
        AluSll  = 4'd8,
        AluSrl  = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        FwdRegf  = 2'd0,
        FwdExmem = 2'd1,
        FwdWb    = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store;
        logic [31:0] npc;
        logic [4:0]  wsel;
        logic [1:0]  memsel;
        logic        regw;
        logic        dwen;
        logic        dren;
    } exmem_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; shifts move operand a by b[4:0].
module alu
    import cpu_types_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  aluop_t      aluop,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        unique case (aluop)
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluXor:  result = a ^ b;
            AluNor:  result = ~(a | b);
            AluSlt:  result = {31'd0, $signed(a) < $signed(b)};
            AluSltu: result = {31'd0, a < b};
            AluSll:  result = a << b[4:0];
            AluSrl:  result = a >> b[4:0];
            default: result = '0;
        endcase
    end

    assign zero = (a == b);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] rdat1_i,
    input  logic [31:0] rdat2_i,
    input  logic [31:0] extout_i,
    input  logic [31:0] jaddr_i,
    input  logic [31:0] npc_i,
    input  aluop_t      aluop_i,
    input  logic        alusrc_i,
    input  logic        lui_i,
    input  logic        branch_i,
    input  logic        bne_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic        regw_i,
    input  logic        dwen_i,
    input  logic        dren_i,
    input  logic        halt_i,
    input  logic [1:0]  memsel_i,
    input  logic [4:0]  wsel_i,
    input  fwd_sel_t    fwda_i,
    input  fwd_sel_t    fwdb_i,
    input  logic [31:0] wbdat_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] alu_o,
    output logic [31:0] store_o,
    output logic [31:0] npc_o,
    output logic [4:0]  wsel_o,
    output logic [1:0]  memsel_o,
    output logic        regw_o,
    output logic        dwen_o,
    output logic        dren_o,
    output logic        halt_o,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    exmem_t      exmem_q, exmem_d;
    logic        halted_q;
    logic [31:0] op_a, fwd_b, alu_b, alu_res, result;
    logic        alu_zero, zero, taken;

    always_comb begin
        unique case (fwda_i)
            FwdExmem: op_a = exmem_q.alu;
            FwdWb:    op_a = wbdat_i;
            default:  op_a = rdat1_i;
        endcase
        unique case (fwdb_i)
            FwdExmem: fwd_b = exmem_q.alu;
            FwdWb:    fwd_b = wbdat_i;
            default:  fwd_b = rdat2_i;
        endcase
    end

    assign alu_b = alusrc_i ? extout_i : fwd_b;

    alu u_alu (
        .a      (op_a),
        .b      (alu_b),
        .aluop  (aluop_i),
        .result (alu_res),
        .zero   (alu_zero)
    );

    assign result = lui_i ? {extout_i[15:0], 16'h0} : alu_res;

    // Branch compare is always against forwarded B, even if the ALU sees the immediate.
    assign zero  = alusrc_i ? (op_a == fwd_b) : alu_zero;
    assign taken = branch_i & (zero ^ bne_i);

    always_comb begin
        if (jr_i)        target_o = op_a;
        else if (jump_i) target_o = jaddr_i;
        else             target_o = npc_i + (extout_i << 2);
    end

    assign redirect_o = (taken | jump_i | jr_i) & ~stall_i & ~halted_q;

    always_comb begin
        exmem_d        = '0;
        exmem_d.alu    = result;
        exmem_d.store  = fwd_b;
        exmem_d.npc    = npc_i;
        exmem_d.wsel   = wsel_i;
        exmem_d.memsel = memsel_i;
        exmem_d.regw   = regw_i;
        exmem_d.dwen   = dwen_i;
        exmem_d.dren   = dren_i;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            exmem_q  <= '0;
            halted_q <= 1'b0;
        end else if (stall_i) begin
            exmem_q  <= exmem_q;
        end else if (flush_i || halted_q) begin
            exmem_q  <= '0;
        end else begin
            exmem_q  <= exmem_d;
            if (halt_i) halted_q <= 1'b1;
        end
    end

    assign alu_o    = exmem_q.alu;
    assign store_o  = exmem_q.store;
    assign npc_o    = exmem_q.npc;
    assign wsel_o   = exmem_q.wsel;
    assign memsel_o = exmem_q.memsel;
    assign regw_o   = exmem_q.regw;
    assign dwen_o   = exmem_q.dwen;
    assign dren_o   = exmem_q.dren;
    // Halt stays visible through the bubbles that follow it until reset.
    assign halt_o   = halted_q;

endmodule
